ones_count_seq: RTL and testbench



---
 rtl/ones_count_seq_if.sv | 21 ++
 rtl/ones_count_seq.sv | 123 ++++++++++++
 tb/tb_ones_count_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ones_count_seq_if.sv
// Handshake bundle for ones_count_seq: start/dat_in request, busy/done/count result.
// The parity signal exists only when ONES_PARITY_EN is defined.
interface ones_count_seq_if #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic [WIDTH-1:0] dat_in;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
`ifdef ONES_PARITY_EN
  logic             parity;

  modport master (output start, dat_in, input busy, done, count, parity);
  modport slave  (input start, dat_in, output busy, done, count, parity);
`else
  modport master (output start, dat_in, input busy, done, count);
  modport slave  (input start, dat_in, output busy, done, count);
`endif
endinterface

// File: rtl/ones_count_seq.sv
// Multi-cycle population counter: latches a WIDTH-bit word, adds CHUNK bits per clock,
// pulses done with the result. Optional parity output enabled by macro ONES_PARITY_EN.
module ones_count_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ones_count_seq_if.slave bus
);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NCYC = WIDTH / CHUNK;
  localparam int IW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int PW   = $clog2(CHUNK + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    r_idx;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_chunk_pop;
  logic [CW-1:0]    w_acc_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (r_idx == IW'(NCYC - 1)) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Popcount of the low chunk, zero-extended into the accumulator width
  always_comb begin
    w_chunk_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_chunk_pop = w_chunk_pop + PW'(r_shreg[i]);
    end
    w_acc_next = r_acc + CW'(w_chunk_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shreg <= bus.dat_in;
        r_acc   <= '0;
        r_idx   <= '0;
      end else if (r_state == S_COUNT) begin
        r_shreg <= r_shreg >> CHUNK;
        r_acc   <= w_acc_next;
        r_idx   <= r_idx + IW'(1);
        if (w_last) begin
          r_count <= w_acc_next;
          r_done  <= 1'b1;
        end
      end
    end
  end

`ifdef ONES_PARITY_EN
  logic r_par_acc;
  logic r_parity;
  logic w_par_next;

  assign w_par_next = r_par_acc ^ (^r_shreg[CHUNK-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par_acc <= 1'b0;
      r_parity  <= 1'b0;
    end else if (w_accept) begin
      r_par_acc <= 1'b0;
    end else if (r_state == S_COUNT) begin
      r_par_acc <= w_par_next;
      if (w_last) begin
        r_parity <= w_par_next;
      end
    end
  end

  assign bus.parity = r_parity;
`endif

  assign bus.busy  = (r_state == S_COUNT);
  assign bus.done  = r_done;
  assign bus.count = r_count;
endmodule

// File: tb/tb_ones_count_seq.sv
// Directed bench for ones_count_seq (WIDTH=32, CHUNK=4): latency, hold, back-to-back,
// mid-count reset; parity checks compiled in with ONES_PARITY_EN.
module tb_ones_count_seq;
  logic i_clk;
  logic i_rst;
  int   errors;
  int   checks;

  ones_count_seq_if #(.WIDTH(32)) bus ();

  ones_count_seq #(.WIDTH(32), .CHUNK(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and follow it to its done pulse.
  task automatic run(input string tag, input logic [31:0] dat, input logic [31:0] dat_mid,
                     input int hold, input logic [5:0] exp_cnt, input logic [5:0] prev_cnt,
                     input bit b2b);
    bit          found;
    bit          held_bad;
    int          lat;
    int          busy_n;
    logic        busy_at_done;
    logic [5:0]  obs_cnt;
`ifdef ONES_PARITY_EN
    logic        obs_par;
`endif
    found = 0; held_bad = 0; lat = 0; busy_n = 0; busy_at_done = 1'b1; obs_cnt = '0;
`ifdef ONES_PARITY_EN
    obs_par = 1'b0;
`endif
    bus.start  = 1'b1;
    bus.dat_in = dat;
    for (int j = 1; j <= 20 && !found; j++) begin
      @(negedge i_clk);
      if (j == hold) bus.start = 1'b0;
      if (j == 1) bus.dat_in = dat_mid;
      if (bus.done) begin
        found        = 1;
        lat          = j - 1;
        obs_cnt      = bus.count;
        busy_at_done = bus.busy;
`ifdef ONES_PARITY_EN
        obs_par      = bus.parity;
`endif
      end else begin
        if (bus.busy) busy_n++;
        if (bus.count !== prev_cnt) held_bad = 1;
      end
    end
    check({tag, " done_seen"}, 32'(found), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, " count_held"}, 32'(held_bad), 32'd0);
    check({tag, " count"}, 32'(obs_cnt), 32'(exp_cnt));
    check({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
`ifdef ONES_PARITY_EN
    check({tag, " parity"}, 32'(obs_par), 32'(exp_cnt[0]));
`endif
    if (!b2b) begin
      @(negedge i_clk);
      check({tag, " done_width"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    int n_done;
    errors     = 0;
    checks     = 0;
    i_rst      = 1'b1;
    bus.start  = 1'b0;
    bus.dat_in = '0;
    repeat (3) @(negedge i_clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst count", 32'(bus.count), 32'd0);
    i_rst = 1'b0;

    run("zero", 32'h0000_0000, 32'h0000_0000, 1, 6'd0, 6'd0, 0);
    run("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 6'd32, 6'd0, 0);

    // start held 3 cycles, data changed after acceptance
    run("hold", 32'h8000_0001, 32'hFFFF_FFFF, 3, 6'd2, 6'd32, 0);
    n_done = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (bus.done) n_done++;
    end
    check("hold extra_done", 32'(n_done), 32'd0);

    // second request issued in the done cycle of the first
    run("b2b_a", 32'h1234_5678, 32'h1234_5678, 1, 6'd13, 6'd2, 1);
    run("b2b_b", 32'h0000_00FF, 32'h0000_00FF, 1, 6'd8, 6'd13, 0);

    // reset during the 3rd COUNT cycle, with start also asserted
    bus.start  = 1'b1;
    bus.dat_in = 32'hF0F0_F0F0;
    @(negedge i_clk);
    bus.start = 1'b0;
    @(negedge i_clk);
    check("abort busy_before", 32'(bus.busy), 32'd1);
    check("abort count_before", 32'(bus.count), 32'd8);
    @(negedge i_clk);
    i_rst     = 1'b1;
    bus.start = 1'b1;
    @(negedge i_clk);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort count", 32'(bus.count), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    i_rst     = 1'b0;
    bus.start = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (bus.done) n_done++;
    end
    check("abort no_done", 32'(n_done), 32'd0);
    check("abort idle", 32'(bus.busy), 32'd0);

    run("top_chunk", 32'hF000_0000, 32'hF000_0000, 1, 6'd4, 6'd0, 0);
`ifdef ONES_PARITY_EN
    run("par7", 32'h0000_0007, 32'h0000_0007, 1, 6'd3, 6'd4, 0);
    run("par3", 32'h0000_0003, 32'h0000_0003, 1, 6'd2, 6'd3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
